da_module: RTL and testbench

DA_MODULE -- requirements
Module: da_module

---
 rtl/da_pkg.sv | 26 ++
 rtl/da_bit_timer.sv | 46 ++++
 rtl/da_module.sv | 175 +++++++++++++++++
 tb/tb_da_module.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// da_pkg: shared FSM state type, default timing constants and a width helper
// for the serial DAC frame generator.
package da_pkg;

  // Frame sequencer states; encoding is arbitrary.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } da_state_e;

  // 46 system clocks per DA bit period: 920 ns at 50 MHz, about 1.09 MHz.
  localparam int DA_CLK_TIME_DEF = 45;
  localparam int DA_CLK_HALF_DEF = 22;
  localparam int DATA_W_DEF      = 10;
  localparam int PAD_BITS_DEF    = 2;
  localparam int GAP_PERIODS_DEF = 2;

  // Bits needed to hold the values 0..last_val; never less than 1.
  function automatic int cnt_width(input int last_val);
    return (last_val < 1) ? 1 : $clog2(last_val + 1);
  endfunction

endpackage

// File: rtl/da_bit_timer.sv
// da_bit_timer: bit-period counter for the DAC serialiser. It counts
// 0..LAST while enabled and wraps to 0. half_o flags count == HALF and
// end_o flags count == LAST, which is the last clock of a bit period.
// clr_i forces the count back to 0 and takes priority over en_i.
module da_bit_timer
  import da_pkg::*;
#(
  parameter int LAST = DA_CLK_TIME_DEF,
  parameter int HALF = DA_CLK_HALF_DEF
) (
  input  logic CLK_50M,
  input  logic RST_N,
  input  logic clr_i,
  input  logic en_i,
  output logic half_o,
  output logic end_o
);

  localparam int W = cnt_width(LAST);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign half_o = (cnt_q == W'(HALF));
  assign end_o  = (cnt_q == W'(LAST));

  // Next count: clear wins, otherwise step and wrap after LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = end_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register; async reset so an aborted frame restarts from zero.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/da_module.sv
// da_module: serial DAC frame generator. It accepts one DATA_W-bit code per
// frame and shifts it out MSB first, followed by PAD_BITS zeros, with chip
// select, serial clock and data all driven from registers.
//
// Build option: define DA_LDAC_EN to add the active-low DA_LDAC_N output.
// It pulses low for one bit period at the start of the inter-frame gap.
// Frame timing is the same with or without it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | data_ready high, DA_CS high, waiting for data_valid
// ST_SETUP | one period with DA_CS low and the MSB on DA_DATA
// ST_SHIFT | DATA_W+PAD_BITS periods; DA_CLK pulses, data shifts on fall
// ST_HOLD  | one period with DA_CS low and DA_CLK/DA_DATA low
// ST_GAP   | GAP_PERIODS periods with DA_CS high, then back to idle
module da_module
  import da_pkg::*;
#(
  parameter int DA_CLK_TIME = DA_CLK_TIME_DEF,
  parameter int DA_CLK_HALF = DA_CLK_HALF_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int PAD_BITS    = PAD_BITS_DEF,
  parameter int GAP_PERIODS = GAP_PERIODS_DEF
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              DA_CS,
  output logic              DA_CLK,
  output logic              DA_DATA
`ifdef DA_LDAC_EN
  ,
  output logic              DA_LDAC_N
`endif
);

  localparam int SR_W     = DATA_W + PAD_BITS;
  localparam int PCNT_MAX = (SR_W > GAP_PERIODS) ? SR_W : GAP_PERIODS;
  localparam int PCNT_W   = cnt_width(PCNT_MAX);

  da_state_e         state_q;
  logic [SR_W-1:0]   shreg_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              cs_q;
  logic              sclk_q;
  logic              sdata_q;
`ifdef DA_LDAC_EN
  logic              ldac_q;
`endif

  logic accept;
  logic tmr_en;
  logic tmr_half;
  logic tmr_end;

  // A code is taken only from idle; anything presented mid-frame is dropped.
  assign accept     = data_valid && (state_q == ST_IDLE);
  assign tmr_en     = (state_q != ST_IDLE);
  assign data_ready = (state_q == ST_IDLE);

  assign DA_CS   = cs_q;
  assign DA_CLK  = sclk_q;
  assign DA_DATA = sdata_q;
`ifdef DA_LDAC_EN
  assign DA_LDAC_N = ldac_q;
`endif

  da_bit_timer #(
    .LAST (DA_CLK_TIME),
    .HALF (DA_CLK_HALF)
  ) u_bit_timer (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .clr_i   (accept),
    .en_i    (tmr_en),
    .half_o  (tmr_half),
    .end_o   (tmr_end)
  );

  // Frame sequencer with registered DAC outputs; every state change happens
  // on a bit-period wrap so the pins never glitch.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      pcnt_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
`ifdef DA_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_valid) begin
            shreg_q <= SR_W'(data_in) << PAD_BITS;
            pcnt_q  <= '0;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            // Present the MSB immediately so it is stable for the whole
            // setup period before the first DA_CLK rise.
            sdata_q <= data_in[DATA_W-1];
            state_q <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          sdata_q <= shreg_q[SR_W-1];
          if (tmr_end) begin
            pcnt_q  <= '0;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tmr_half) begin
            sclk_q <= 1'b1;
          end
          if (tmr_end) begin
            // Falling DA_CLK and the next data bit land on the same edge,
            // half a period after the DAC sampled the current bit.
            sclk_q  <= 1'b0;
            shreg_q <= {shreg_q[SR_W-2:0], 1'b0};
            if (pcnt_q == PCNT_W'(SR_W - 1)) begin
              sdata_q <= 1'b0;
              state_q <= ST_HOLD;
            end else begin
              sdata_q <= shreg_q[SR_W-2];
              pcnt_q  <= pcnt_q + PCNT_W'(1);
            end
          end
        end

        ST_HOLD: begin
          if (tmr_end) begin
            cs_q    <= 1'b1;
            pcnt_q  <= '0;
`ifdef DA_LDAC_EN
            ldac_q  <= 1'b0;
`endif
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tmr_end) begin
`ifdef DA_LDAC_EN
            ldac_q <= 1'b1;
`endif
            if (pcnt_q == PCNT_W'(GAP_PERIODS - 1)) begin
              pcnt_q  <= '0;
              state_q <= ST_IDLE;
            end else begin
              pcnt_q <= pcnt_q + PCNT_W'(1);
            end
          end
        end

        default: begin
          cs_q    <= 1'b1;
          sclk_q  <= 1'b0;
          sdata_q <= 1'b0;
`ifdef DA_LDAC_EN
          ldac_q  <= 1'b1;
`endif
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_module.sv
// tb_da_module: directed bench for da_module. A vector table of codes with
// hand-computed serial bit patterns drives whole frames; hand-written
// sequences cover idle after reset and reset asserted mid-frame.
module tb_da_module;

  logic       CLK_50M = 1'b0;
  logic       RST_N;
  logic [9:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       DA_CS;
  logic       DA_CLK;
  logic       DA_DATA;
`ifdef DA_LDAC_EN
  logic       DA_LDAC_N;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [9:0]  code;
    logic [11:0] bits;
    int          mode;   // 0: single pulse, 1: hold valid, 2: disturb mid-shift
  } vec_t;

  vec_t vecs [6];

  da_module dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .DA_CS      (DA_CS),
    .DA_CLK     (DA_CLK),
    .DA_DATA    (DA_DATA)
`ifdef DA_LDAC_EN
    ,
    .DA_LDAC_N  (DA_LDAC_N)
`endif
  );

  always #10 CLK_50M = ~CLK_50M;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!data_ready && k < 3000) begin
      @(negedge CLK_50M);
      k++;
    end
    ok = data_ready;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // Drives one code and observes the frame until data_ready returns.
  task automatic run_frame(input logic [9:0] code, input logic [11:0] exp_bits,
                           input int mode);
    int          n       = 0;
    int          rises   = 0;
    int          cs_lo   = 0;
    int          gap_hi  = 0;
    int          hold_hi = 0;
    logic [11:0] bits    = '0;
    logic        prev_clk = 1'b0;
    bit          done    = 0;
    bit          ok;
`ifdef DA_LDAC_EN
    int          ldac_lo    = 0;
    int          ldac_start = -1;
`endif
    wait_ready(ok);
    if (!ok) return;
    data_in    = code;
    data_valid = 1'b1;
    @(posedge CLK_50M);
    while (!done) begin
      @(negedge CLK_50M);
      if (n == 0) begin
        check($sformatf("accept_%h", code), int'(data_ready), 0);
        if (mode != 1) data_valid = 1'b0;
      end
      if (mode == 2 && n == 300) begin
        data_in    = ~code;
        data_valid = 1'b1;
      end
      if (mode == 2 && n == 301) data_valid = 1'b0;
      if (data_ready) begin
        done = 1;
      end else begin
        if (DA_CLK && !prev_clk) begin
          bits = {bits[10:0], DA_DATA};
          rises++;
        end
        prev_clk = DA_CLK;
        if (!DA_CS) cs_lo++;
        else if (cs_lo > 0) gap_hi++;
        if (n >= 598 && n < 644 && (DA_DATA || DA_CLK)) hold_hi++;
`ifdef DA_LDAC_EN
        if (!DA_LDAC_N) begin
          if (ldac_lo == 0) ldac_start = n;
          ldac_lo++;
        end
`endif
        n++;
        if (n > 2000) begin
          check($sformatf("frame_timeout_%h", code), n, 736);
          done = 1;
        end
      end
    end
    check($sformatf("bits_%h", code), int'(bits), int'(exp_bits));
    check($sformatf("rises_%h", code), rises, 12);
    check($sformatf("cs_low_%h", code), cs_lo, 644);
    check($sformatf("gap_high_%h", code), gap_hi, 92);
    check($sformatf("hold_quiet_%h", code), hold_hi, 0);
    check($sformatf("frame_len_%h", code), n, 736);
`ifdef DA_LDAC_EN
    check($sformatf("ldac_len_%h", code), ldac_lo, 46);
    check($sformatf("ldac_start_%h", code), ldac_start, 644);
`endif
  endtask

  // Watches the pins for a number of cycles and checks nothing moves.
  task automatic idle_watch(input string nm, input int cycles);
    int clk_hi = 0, cs_lo = 0, rdy_lo = 0, dat_hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK_50M);
      if (DA_CLK) clk_hi++;
      if (!DA_CS) cs_lo++;
      if (!data_ready) rdy_lo++;
      if (DA_DATA) dat_hi++;
    end
    check({nm, "_clk_high"}, clk_hi, 0);
    check({nm, "_cs_low"}, cs_lo, 0);
    check({nm, "_ready_low"}, rdy_lo, 0);
    check({nm, "_data_high"}, dat_hi, 0);
  endtask

  initial begin
    int   rises;
    int   k;
    logic prev_clk;
    bit   ok;

    vecs[0] = '{10'h2A5, 12'hA94, 0};
    vecs[1] = '{10'h3FF, 12'hFFC, 1};
    vecs[2] = '{10'h000, 12'h000, 0};
    vecs[3] = '{10'h155, 12'h554, 2};
    vecs[4] = '{10'h001, 12'h004, 0};
    vecs[5] = '{10'h200, 12'h800, 0};

    RST_N      = 1'b0;
    data_in    = 10'h155;
    data_valid = 1'b0;
    repeat (3) @(negedge CLK_50M);
    check("rst_cs", int'(DA_CS), 1);
    check("rst_clk", int'(DA_CLK), 0);
    check("rst_data", int'(DA_DATA), 0);
    check("rst_ready", int'(data_ready), 1);
`ifdef DA_LDAC_EN
    check("rst_ldac", int'(DA_LDAC_N), 1);
`endif
    RST_N = 1'b1;

    idle_watch("idle", 1000);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].code, vecs[v].bits, vecs[v].mode);
      if (vecs[v].mode == 2) idle_watch("no_extra", 200);
    end

    // Reset asserted at the fifth DA_CLK rise of a frame.
    wait_ready(ok);
    data_in    = 10'h2A5;
    data_valid = 1'b1;
    @(posedge CLK_50M);
    @(negedge CLK_50M);
    data_valid = 1'b0;
    rises    = 0;
    k        = 0;
    prev_clk = 1'b0;
    while (rises < 5 && k < 2000) begin
      if (DA_CLK && !prev_clk) rises++;
      prev_clk = DA_CLK;
      if (rises < 5) begin
        @(negedge CLK_50M);
        k++;
      end
    end
    check("abort_rise_count", rises, 5);
    RST_N = 1'b0;
    #1;
    check("abort_cs", int'(DA_CS), 1);
    check("abort_clk", int'(DA_CLK), 0);
    check("abort_ready", int'(data_ready), 1);
    repeat (3) @(negedge CLK_50M);
    RST_N = 1'b1;
    idle_watch("post_abort", 200);
    run_frame(10'h2A5, 12'hA94, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
